// File: rtl/j1_uart_io.sv
// j1_uart_io: j1 I/O-bus UART responder, 8N1 serial TX/RX with a status register.
// Define UART_RX_FIFO_EN to replace the single RX holding register with an RX_DEPTH-entry FIFO.
module j1_uart_io #(
  parameter int WIDTH = 32,
  parameter int CLKS_PER_BIT = 417,
  parameter logic [WIDTH-1:0] ADDR_DATA = 'h1000,
  parameter logic [WIDTH-1:0] ADDR_STAT = 'h2000,
  parameter int RX_DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [WIDTH-1:0] io_addr,
  input  logic [WIDTH-1:0] io_wdata,
  output logic [WIDTH-1:0] io_rdata,
  input  logic             uart_rx,
  output logic             uart_tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_MID = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BRK} rx_state_t;
  tx_state_t tx_state_q, tx_state_d;
  rx_state_t rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, hold_q, hold_d, rx_byte;
  logic tx_q, tx_d, hold_full_q, hold_full_d, sync1_q, sync2_q, ovr_q, ovr_d, ferr_q, ferr_d;
  logic rd_data, rd_stat, wr_data, tx_end, rx_end, load, deliver, ferr_set, ovr_set, pop, rx_valid;
  logic unused_ok;
  assign unused_ok = ^io_wdata[WIDTH-1:8];
  assign uart_tx = tx_q;
  always_comb begin
    rd_data = io_rd & (io_addr == ADDR_DATA);
    rd_stat = io_rd & (io_addr == ADDR_STAT);
    wr_data = io_wr & (io_addr == ADDR_DATA);
    io_rdata = (io_addr == ADDR_DATA) ? {{(WIDTH-8){1'b0}}, rx_byte}
             : (io_addr == ADDR_STAT) ? {{(WIDTH-5){1'b0}}, ferr_q, tx_state_q != T_IDLE, ovr_q, rx_valid, !hold_full_q}
             : '0;
    ferr_d = ferr_set | (ferr_q & !rd_stat);
    ovr_d = ovr_set | (ovr_q & !rd_stat);
  end
  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_d = tx_q;
    hold_d = hold_q;
    hold_full_d = hold_full_q;
    tx_end = tx_cnt_q == C_END;
    tx_cnt_d = (tx_state_q == T_IDLE) ? tx_cnt_q : tx_end ? '0 : tx_cnt_q + 1'b1;
    load = 1'b0;
    case (tx_state_q)
      T_IDLE: load = hold_full_q;
      T_START: if (tx_end) begin
        tx_state_d = T_DATA;
        tx_d = tx_sh_q[0];
      end
      T_DATA: if (tx_end) begin
        tx_bit_d = tx_bit_q + 3'd1;
        tx_sh_d = tx_sh_q >> 1;
        tx_state_d = (tx_bit_q == 3'd7) ? T_STOP : T_DATA;
        tx_d = (tx_bit_q == 3'd7) | tx_sh_q[1];
      end
      T_STOP: if (tx_end) begin
        tx_state_d = T_IDLE;
        load = hold_full_q;
      end
    endcase
    // End of STOP reloads straight into START so back-to-back bytes have no idle gap.
    if (load) begin
      tx_state_d = T_START;
      tx_sh_d = hold_q;
      tx_d = 1'b0;
      tx_cnt_d = '0;
      tx_bit_d = '0;
      hold_full_d = 1'b0;
    end
    if (wr_data && !hold_full_q) begin
      hold_d = io_wdata[7:0];
      hold_full_d = 1'b1;
    end
  end
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_end = rx_cnt_q == C_END;
    rx_cnt_d = rx_end ? '0 : rx_cnt_q + 1'b1;
    deliver = 1'b0;
    ferr_set = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (!sync2_q) rx_state_d = R_START;
      end
      R_START: if (rx_cnt_q == C_MID) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_state_d = sync2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_end) begin
        rx_sh_d = {sync2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
      end
      R_STOP: if (rx_end) begin
        deliver = sync2_q;
        ferr_set = !sync2_q;
        rx_state_d = sync2_q ? R_IDLE : R_BRK;
      end
      R_BRK: if (sync2_q) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end
`ifdef UART_RX_FIFO_EN
  localparam int PW = $clog2(RX_DEPTH);
  logic [7:0] mem_q [RX_DEPTH];
  logic [PW:0] wp_q, wp_d, rp_q, rp_d;
  logic full, push;
  always_comb begin
    full = (wp_q - rp_q) == (PW+1)'(RX_DEPTH);
    rx_valid = wp_q != rp_q;
    rx_byte = mem_q[rp_q[PW-1:0]];
    pop = rd_data & rx_valid;
    push = deliver & (!full | pop);
    ovr_set = deliver & full & !pop;
    wp_d = wp_q + (PW+1)'(push);
    rp_d = rp_q + (PW+1)'(pop);
  end
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      if (push) mem_q[wp_q[PW-1:0]] <= rx_sh_q;
    end
`else
  logic rx_valid_q, rx_valid_d, unused_depth;
  logic [7:0] rx_byte_q, rx_byte_d;
  assign unused_depth = 1'(RX_DEPTH);
  always_comb begin
    rx_valid = rx_valid_q;
    rx_byte = rx_byte_q;
    pop = rd_data & rx_valid_q;
    ovr_set = deliver & rx_valid_q & !pop;
    rx_valid_d = deliver | (rx_valid_q & !pop);
    rx_byte_d = (deliver & !ovr_set) ? rx_sh_q : rx_byte_q;
  end
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      rx_valid_q <= 1'b0;
      rx_byte_q <= '0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_byte_q <= rx_byte_d;
    end
`endif
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      tx_state_q <= T_IDLE;
      rx_state_q <= R_IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_bit_q <= '0;
      rx_bit_q <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      hold_q <= '0;
      hold_full_q <= 1'b0;
      tx_q <= 1'b1;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_bit_q <= tx_bit_d;
      rx_bit_q <= rx_bit_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q <= tx_d;
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
    end
endmodule

// File: tb/tb_j1_uart_io.sv
// tb_j1_uart_io: scoreboard bench for j1_uart_io; expected read data and TX frames are queued by the
// stimulus from a timing/queue reference model and compared by independent monitors.
module tb_j1_uart_io;
  localparam int CPB = 4;
  localparam int FB = 10 * CPB;
`ifdef UART_RX_FIFO_EN
  localparam int D = 8;
`else
  localparam int D = 1;
`endif
  localparam logic [31:0] A_DATA = 32'h1000;
  localparam logic [31:0] A_STAT = 32'h2000;
  logic clk = 0, resetq = 0, io_rd = 0, io_wr = 0, uart_rx = 1;
  logic [31:0] io_addr = 0, io_wdata = 0;
  logic [31:0] io_rdata;
  logic uart_tx;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int s_last = -1000, s_prev = -1000;
  logic [7:0] rxq[$], hist[$], tx_b[$];
  int tx_s[$];
  logic [31:0] rd_exp[$];
  string rd_name[$];
  bit ovr = 0, ferr = 0;

  j1_uart_io #(.WIDTH(32), .CLKS_PER_BIT(CPB), .ADDR_DATA(A_DATA), .ADDR_STAT(A_STAT), .RX_DEPTH(8)) dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Status after clock edge n: holding is full from the accepting write until its frame starts;
  // the shifter is busy for FB cycles from each frame start.
  function automatic logic [31:0] stat_exp(int n);
    logic busy;
    busy = (n >= s_last && n < s_last + FB) || (n >= s_prev && n < s_prev + FB);
    return {27'b0, ferr, busy, ovr, rxq.size() != 0, s_last <= n};
  endfunction

  task automatic rd(logic [31:0] a, string name);
    logic [31:0] e;
    e = 0;
    if (a == A_STAT) e = stat_exp(cyc);
    else if (a == A_DATA) begin
      if (rxq.size() != 0) e = {24'b0, rxq[0]};
      else if (hist.size() >= D) e = {24'b0, hist[hist.size() - D]};
    end
    rd_exp.push_back(e);
    rd_name.push_back(name);
    io_addr = a;
    io_rd = 1;
    tick();
    io_rd = 0;
    if (a == A_DATA && rxq.size() != 0) void'(rxq.pop_front());
    if (a == A_STAT) begin
      ovr = 0;
      ferr = 0;
    end
  endtask

  task automatic wr(logic [31:0] a, logic [7:0] b);
    int w;
    w = cyc + 1;
    if (a == A_DATA && s_last < w) begin
      s_prev = s_last;
      s_last = (w + 1 > s_last + FB) ? w + 1 : s_last + FB;
      tx_b.push_back(b);
      tx_s.push_back(s_last);
    end
    io_addr = a;
    io_wdata = $urandom();
    io_wdata[7:0] = b;
    io_wr = 1;
    tick();
    io_wr = 0;
  endtask

  task automatic send_rx(logic [7:0] b, bit good);
    logic [9:0] f;
    f = {good, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      tick(CPB);
    end
    uart_rx = 1;
    tick(CPB + 2);
    if (!good) ferr = 1;
    else if (rxq.size() < D) begin
      rxq.push_back(b);
      hist.push_back(b);
    end else ovr = 1;
  endtask

  task automatic glitch();
    uart_rx = 0;
    tick(2);
    uart_rx = 1;
    tick(8);
  endtask

  initial begin : mon_tx
    logic [39:0] wave, ew;
    logic [9:0] f;
    int n, st;
    n = 0;
    st = 0;
    wave = '0;
    forever begin
      @(negedge clk);
      if (!resetq) n = 0;
      else if (n == 0) begin
        if (uart_tx == 0) begin
          st = cyc;
          wave[0] = 1'b0;
          n = 1;
        end
      end else begin
        wave[n] = uart_tx;
        n++;
        if (n == FB) begin
          n = 0;
          check("tx_frame_queued", tx_b.size() != 0, 1);
          if (tx_b.size() != 0) begin
            f = {1'b1, tx_b.pop_front(), 1'b0};
            for (int i = 0; i < FB; i++) ew[i] = f[i / CPB];
            check("tx_wave", wave, ew);
            check("tx_start_cycle", st, tx_s.pop_front());
          end
        end
      end
    end
  end

  initial begin : mon_rd
    forever begin
      @(negedge clk);
      if (io_rd) begin
        if (rd_exp.size() == 0) check("rd_queued", rd_exp.size(), 1);
        else check(rd_name.pop_front(), io_rdata, rd_exp.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    tick(3);
    resetq = 1;
    tick(2);
    check("reset_uart_tx", uart_tx, 1);
    rd(A_STAT, "reset_stat");
    rd(A_DATA, "reset_data");
    rd(32'h3000, "unmapped_read");
    wr(A_DATA, 8'hA5);
    tick(3);
    rd(A_STAT, "tx_busy_stat");
    tick(FB);
    wr(A_DATA, 8'h55);
    tick(5);
    wr(A_DATA, 8'hAA);
    rd(A_STAT, "holding_full_stat");
    tick(3);
    wr(A_DATA, 8'h33);
    rd(A_STAT, "dropped_write_stat");
    wr(A_STAT, 8'h77);
    tick(2 * FB);
    send_rx(8'h3C, 1);
    rd(A_STAT, "rx_valid_stat");
    rd(A_DATA, "rx_data_3c");
    rd(A_STAT, "rx_popped_stat");
    send_rx(8'h11, 1);
    send_rx(8'h22, 1);
    rd(A_DATA, "rx_first_of_two");
    rd(A_STAT, "overrun_stat");
    rd(A_STAT, "overrun_cleared_stat");
    rd(A_DATA, "rx_second_or_stale");
    send_rx(8'h5A, 0);
    rd(A_STAT, "frame_err_stat");
    glitch();
    rd(A_STAT, "glitch_stat");
    rd(A_DATA, "glitch_data");
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0, 1: wr(($urandom_range(0, 7) == 0) ? A_STAT : A_DATA, 8'($urandom));
        2: rd(A_STAT, "rnd_stat");
        3: rd(A_DATA, "rnd_data");
        4, 5: send_rx(8'($urandom), $urandom_range(0, 5) != 0);
        6: glitch();
        default: tick($urandom_range(1, 30));
      endcase
    end
    for (int t = 0; t < 400 && tx_b.size() != 0; t++) tick();
    tick(2);
    check("tx_drained", tx_b.size(), 0);
    wr(A_DATA, 8'hC3);
    tick(12);
    resetq = 0;
    #1;
    check("async_reset_uart_tx", uart_tx, 1);
    tx_b.delete();
    tx_s.delete();
    rxq.delete();
    hist.delete();
    s_last = -1000;
    s_prev = -1000;
    ovr = 0;
    ferr = 0;
    tick(3);
    resetq = 1;
    tick(1);
    rd(A_STAT, "post_reset_stat");
    tick(FB + 4);
    check("rd_drained", rd_exp.size(), 0);
    check("no_tx_after_reset", tx_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
